// File: rtl/uart_tx_fifo_rd_pkg.sv
// rtl/uart_tx_fifo_rd_pkg.sv - shared UART definitions: FSM state encoding and default frame constants
//
// Purpose: state encoding and default parameter values shared by the UART
// transmitter and anything that needs to agree with its frame format.
package uart_tx_fifo_rd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_tx_state_e;

  localparam int DEF_DBIT       = 8;
  localparam int DEF_SB_TICK    = 16;
  localparam int DEF_OVERSAMPLE = 16;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_rd.sv
// rtl/uart_tx_fifo_rd.sv - UART transmitter popping words from the read side of a TX FIFO
//
// Purpose: while idle, pops one word whenever the FIFO is non-empty and sends
// it as start bit, DBIT data bits (LSB first) and a stop period of SB_TICK
// baud ticks. Bit timing is counted in oversampling baud ticks (s_tick).
//
// Ports:
//   clk          - system clock
//   reset        - synchronous, active-high
//   s_tick       - baud tick, one-cycle pulse, OVERSAMPLE per bit period
//   fifo_empty   - FIFO empty flag
//   fifo_data    - FIFO read data, valid combinationally while fifo_empty=0
//   fifo_rd      - FIFO pop strobe (combinational, IDLE and non-empty only)
//   tx           - serial line, idle high (registered)
//   tx_busy      - high while a frame is in progress (registered)
//   tx_done_tick - one-cycle pulse at the end of the stop period (registered)
module uart_tx_fifo_rd
  import uart_tx_fifo_rd_pkg::*;
#(
  parameter int DBIT       = DEF_DBIT,
  parameter int SB_TICK    = DEF_SB_TICK,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            fifo_empty,
  input  logic [DBIT-1:0] fifo_data,
  output logic            fifo_rd,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done_tick
);

  localparam int TICK_MAX = max_int(OVERSAMPLE, SB_TICK);
  localparam int TW       = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
  localparam int BW       = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [TW-1:0] OS_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] SB_LAST  = TW'(SB_TICK - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DBIT - 1);

  uart_tx_state_e  state_q, state_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [DBIT-1:0] shreg_q, shreg_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    fifo_rd = 1'b0;
    tx_d    = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_rd = 1'b1;
          shreg_d = fifo_data;
          tick_d  = '0;
          busy_d  = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (s_tick) begin
          if (tick_q == OS_LAST) begin
            tick_d  = '0;
            bit_d   = '0;
            state_d = ST_DATA;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      ST_DATA: begin
        if (s_tick) begin
          if (tick_q == OS_LAST) begin
            tick_d  = '0;
            shreg_d = shreg_q >> 1;
            if (bit_q == BIT_LAST) begin
              state_d = ST_STOP;
            end else begin
              bit_d = bit_q + BW'(1);
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      ST_STOP: begin
        if (s_tick) begin
          if (tick_q == SB_LAST) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // tx is registered, so it is derived from the state being entered; in DATA
    // the shifted register already holds the bit that goes out next.
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shreg_d[0];
      default:  tx_d = 1'b1;
    endcase

    // A word popped now would be lost when reset wipes the shift register.
    if (reset) begin
      fifo_rd = 1'b0;
    end
  end

  assign tx           = tx_q;
  assign tx_busy      = busy_q;
  assign tx_done_tick = done_q;

endmodule
